// File: rtl/multi_button_debounce_pkg.sv
// -----------------------------------------------------------------------------
// multi_button_debounce_pkg
//
// Shared definitions for the multi-channel button debouncer:
//   - count_width(): bits needed to hold a count of 0..max_value (min 1 bit)
//   - max_of():      larger of two integers, for sizing shared counters
//   - pulse_t:       the registered per-channel edge pulses
//
// Optional feature macro used by the design: MULTI_BUTTON_DEBOUNCE_REPEAT_EN
// -----------------------------------------------------------------------------
package multi_button_debounce_pkg;

    // Equivalent to $clog2(max_value + 1), but never returns zero.
    function automatic int count_width(input int max_value);
        return (max_value <= 0) ? 1 : $clog2(max_value + 1);
    endfunction

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    typedef struct packed {
        logic went_active;
        logic went_inactive;
        logic changed;
    } pulse_t;

endpackage

// File: rtl/multi_button_debounce_channel.sv
// -----------------------------------------------------------------------------
// multi_button_debounce_channel
//
// One debounced input: polarity correction, METASTABLE_CLOCK_PERIODS-deep
// synchroniser, saturating stability counter, debounced level and registered
// one-cycle edge pulses. With MULTI_BUTTON_DEBOUNCE_REPEAT_EN defined it also
// produces hold-to-repeat pulses; otherwise repeat_pulse is tied to 0.
//
// Ports:
//   clock          system clock, all state on posedge
//   reset_n        asynchronous active-low reset
//   raw            raw asynchronous input
//   state          debounced level, 1 = active
//   went_active    1-cycle pulse on accepted inactive->active
//   went_inactive  1-cycle pulse on accepted active->inactive
//   changed        1-cycle pulse on any accepted change
//   repeat_pulse   1-cycle auto-repeat pulse while held active
// -----------------------------------------------------------------------------
module multi_button_debounce_channel
    import multi_button_debounce_pkg::*;
#(
    parameter int DEBOUNCE_CLOCK_PERIODS   = 20,
    parameter int METASTABLE_CLOCK_PERIODS = 3,
    parameter bit ACTIVE_LOW               = 1'b0,
    parameter int HOLD_CLOCK_PERIODS       = 1000,
    parameter int REPEAT_CLOCK_PERIODS     = 250
) (
    input  logic clock,
    input  logic reset_n,
    input  logic raw,
    output logic state,
    output logic went_active,
    output logic went_inactive,
    output logic changed,
    output logic repeat_pulse
);

    // Parameter range checks, reported at elaboration.
    if (DEBOUNCE_CLOCK_PERIODS < 1) begin : g_bad_debounce
        $error("DEBOUNCE_CLOCK_PERIODS must be >= 1");
    end
    if (METASTABLE_CLOCK_PERIODS < 2) begin : g_bad_metastable
        $error("METASTABLE_CLOCK_PERIODS must be >= 2");
    end
    if (HOLD_CLOCK_PERIODS < 1 || REPEAT_CLOCK_PERIODS < 1) begin : g_bad_repeat
        $error("HOLD_CLOCK_PERIODS and REPEAT_CLOCK_PERIODS must be >= 1");
    end

    localparam int CNT_W = count_width(DEBOUNCE_CLOCK_PERIODS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CLOCK_PERIODS - 1);

    logic [METASTABLE_CLOCK_PERIODS-1:0] sync_q;
    logic [CNT_W-1:0]                    cnt_q;
    logic                                state_q;
    pulse_t                              pulse_q;

    logic sample;
    logic mismatch;
    logic accept;

    // Polarity is corrected before the synchroniser so that reset (all flops
    // 0) already matches an idle input of either polarity: no spurious edge.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours, as real flops do.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[METASTABLE_CLOCK_PERIODS-2:0], raw ^ ACTIVE_LOW};
        end
    end

    assign sample   = sync_q[METASTABLE_CLOCK_PERIODS-1];
    assign mismatch = (sample != state_q);
    assign accept   = mismatch && (cnt_q == CNT_LAST);

    // Any sample agreeing with the current level restarts the count, so only
    // DEBOUNCE_CLOCK_PERIODS consecutive disagreeing samples flip the state.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q   <= '0;
            state_q <= 1'b0;
            pulse_q <= '0;
        end else begin
            if (!mismatch || accept) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (accept) begin
                state_q <= sample;
            end
            pulse_q <= '{went_active:   accept &  sample,
                         went_inactive: accept & ~sample,
                         changed:       accept};
        end
    end

    assign state         = state_q;
    assign went_active   = pulse_q.went_active;
    assign went_inactive = pulse_q.went_inactive;
    assign changed       = pulse_q.changed;

`ifdef MULTI_BUTTON_DEBOUNCE_REPEAT_EN
    localparam int HOLD_W = count_width(max_of(HOLD_CLOCK_PERIODS, REPEAT_CLOCK_PERIODS));
    localparam logic [HOLD_W-1:0] HOLD_LAST   = HOLD_W'(HOLD_CLOCK_PERIODS - 1);
    localparam logic [HOLD_W-1:0] REPEAT_LAST = HOLD_W'(REPEAT_CLOCK_PERIODS - 1);

    logic [HOLD_W-1:0] hold_cnt_q;
    logic              repeating_q;   // first repeat already issued
    logic              repeat_q;

    // Counting runs only while the level is held active and no change is
    // being accepted; a release edge therefore suppresses any coincident
    // repeat, and the activation edge restarts the hold interval.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hold_cnt_q  <= '0;
            repeating_q <= 1'b0;
            repeat_q    <= 1'b0;
        end else if (!state_q || accept) begin
            hold_cnt_q  <= '0;
            repeating_q <= 1'b0;
            repeat_q    <= 1'b0;
        end else if (hold_cnt_q == (repeating_q ? REPEAT_LAST : HOLD_LAST)) begin
            hold_cnt_q  <= '0;
            repeating_q <= 1'b1;
            repeat_q    <= 1'b1;
        end else begin
            hold_cnt_q  <= hold_cnt_q + HOLD_W'(1);
            repeat_q    <= 1'b0;
        end
    end

    assign repeat_pulse = repeat_q;
`else
    assign repeat_pulse = 1'b0;
`endif

endmodule

// File: rtl/multi_button_debounce.sv
// -----------------------------------------------------------------------------
// multi_button_debounce
//
// CHANNELS independent button debouncers in the single system clock domain.
// Each raw input is polarity-corrected (ACTIVE_LOW_MASK), synchronised and
// filtered; the top only replicates the channel and OR-reduces the change
// pulses into any_just_changed.
//
// Optional feature: define MULTI_BUTTON_DEBOUNCE_REPEAT_EN to enable
// hold-to-repeat pulses on button_repeat (HOLD_/REPEAT_CLOCK_PERIODS);
// without it button_repeat is constant 0.
//
// Ports:
//   clock                      system clock
//   reset_n                    asynchronous active-low reset
//   button_raw[CHANNELS]       raw asynchronous inputs
//   button_state[CHANNELS]     debounced levels, 1 = active
//   button_just_went_active    1-cycle pulse per channel on accepted press
//   button_just_went_inactive  1-cycle pulse per channel on accepted release
//   button_just_changed        OR of the two pulses, per channel
//   any_just_changed           OR-reduction of button_just_changed
//   button_repeat              1-cycle auto-repeat pulses per channel
// -----------------------------------------------------------------------------
module multi_button_debounce
    import multi_button_debounce_pkg::*;
#(
    parameter int                  CHANNELS                 = 4,
    parameter int                  DEBOUNCE_CLOCK_PERIODS   = 20,
    parameter int                  METASTABLE_CLOCK_PERIODS = 3,
    parameter logic [CHANNELS-1:0] ACTIVE_LOW_MASK          = '0,
    parameter int                  HOLD_CLOCK_PERIODS       = 1000,
    parameter int                  REPEAT_CLOCK_PERIODS     = 250
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [CHANNELS-1:0] button_raw,
    output logic [CHANNELS-1:0] button_state,
    output logic [CHANNELS-1:0] button_just_went_active,
    output logic [CHANNELS-1:0] button_just_went_inactive,
    output logic [CHANNELS-1:0] button_just_changed,
    output logic                any_just_changed,
    output logic [CHANNELS-1:0] button_repeat
);

    if (CHANNELS < 1) begin : g_bad_channels
        $error("CHANNELS must be >= 1");
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_channel
        multi_button_debounce_channel #(
            .DEBOUNCE_CLOCK_PERIODS  (DEBOUNCE_CLOCK_PERIODS),
            .METASTABLE_CLOCK_PERIODS(METASTABLE_CLOCK_PERIODS),
            .ACTIVE_LOW              (ACTIVE_LOW_MASK[i]),
            .HOLD_CLOCK_PERIODS      (HOLD_CLOCK_PERIODS),
            .REPEAT_CLOCK_PERIODS    (REPEAT_CLOCK_PERIODS)
        ) u_channel (
            .clock        (clock),
            .reset_n      (reset_n),
            .raw          (button_raw[i]),
            .state        (button_state[i]),
            .went_active  (button_just_went_active[i]),
            .went_inactive(button_just_went_inactive[i]),
            .changed      (button_just_changed[i]),
            .repeat_pulse (button_repeat[i])
        );
    end

    // Built from registered pulses, so it is itself a clean 1-cycle pulse.
    assign any_just_changed = |button_just_changed;

endmodule

// File: tb/tb_multi_button_debounce.sv
module tb_multi_button_debounce;

    localparam int CH = 4;
    localparam int D  = 10;
    localparam int M  = 3;
    localparam int H  = 50;
    localparam int R  = 20;
    localparam logic [CH-1:0] MASK = 4'b1000;
    localparam logic [CH-1:0] IDLE = 4'b1000;   // raw level of all-released buttons
    localparam int MAXT = 8192;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic [CH-1:0] button_raw = IDLE;
    logic [CH-1:0] button_state;
    logic [CH-1:0] button_just_went_active;
    logic [CH-1:0] button_just_went_inactive;
    logic [CH-1:0] button_just_changed;
    logic          any_just_changed;
    logic [CH-1:0] button_repeat;

    multi_button_debounce #(
        .CHANNELS                (CH),
        .DEBOUNCE_CLOCK_PERIODS  (D),
        .METASTABLE_CLOCK_PERIODS(M),
        .ACTIVE_LOW_MASK         (MASK),
        .HOLD_CLOCK_PERIODS      (H),
        .REPEAT_CLOCK_PERIODS    (R)
    ) dut (
        .clock                    (clock),
        .reset_n                  (reset_n),
        .button_raw               (button_raw),
        .button_state             (button_state),
        .button_just_went_active  (button_just_went_active),
        .button_just_went_inactive(button_just_went_inactive),
        .button_just_changed      (button_just_changed),
        .any_just_changed         (any_just_changed),
        .button_repeat            (button_repeat)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Edge index t counts posedges since reset release (first edge = 1).
    // hist[e] is the polarity-corrected input present at edge e. The filtered
    // sample seen at edge e is the input from M edges earlier. A level flips
    // at edge t when the D most recent samples all disagree with it and the
    // previous flip is at least D edges back.
    int            t;
    logic [CH-1:0] hist [MAXT];
    int            last_flip [CH];
    int            rise_edge [CH];
    logic [CH-1:0] m_state;

    task automatic model_reset();
        t = 0;
        m_state = '0;
        for (int c = 0; c < CH; c++) begin
            last_flip[c] = -100000;
            rise_edge[c] = -100000;
        end
    endtask

    function automatic logic samp(input int e, input int c);
        if (e - M >= 1) return hist[e - M][c];
        return 1'b0;
    endfunction

    task automatic step(input logic [CH-1:0] raw_val);
        logic [CH-1:0] e_act, e_inact, e_rep;
        logic          flip;
        @(negedge clock);
        button_raw = raw_val;
        @(posedge clock);
        if (t < MAXT - 1) t++;
        hist[t] = raw_val ^ MASK;
        e_act = '0; e_inact = '0; e_rep = '0;
        for (int c = 0; c < CH; c++) begin
            flip = (t - last_flip[c] >= D);
            for (int k = 0; k < D; k++) begin
                if (t - k < 1 || samp(t - k, c) == m_state[c]) flip = 1'b0;
            end
            if (!flip && m_state[c] && (t - rise_edge[c] >= H) &&
                ((t - rise_edge[c] - H) % R == 0))
                e_rep[c] = 1'b1;
            if (flip) begin
                e_act[c]   = ~m_state[c];
                e_inact[c] =  m_state[c];
                m_state[c] = ~m_state[c];
                last_flip[c] = t;
                if (m_state[c]) rise_edge[c] = t;
            end
        end
`ifndef MULTI_BUTTON_DEBOUNCE_REPEAT_EN
        e_rep = '0;
`endif
        #1;
        check("state",    button_state,              m_state);
        check("act",      button_just_went_active,   e_act);
        check("inact",    button_just_went_inactive, e_inact);
        check("changed",  button_just_changed,       e_act | e_inact);
        check("any",      any_just_changed,          |(e_act | e_inact));
        check("repeat",   button_repeat,             e_rep);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_state"},   button_state,              '0);
        check({tag, "_act"},     button_just_went_active,   '0);
        check({tag, "_inact"},   button_just_went_inactive, '0);
        check({tag, "_changed"}, button_just_changed,       '0);
        check({tag, "_any"},     any_just_changed,          '0);
        check({tag, "_repeat"},  button_repeat,             '0);
    endtask

    // Assert reset between edges, check outputs clear at once, release just
    // after a posedge so the next step() edge is edge 1.
    task automatic apply_reset(input logic [CH-1:0] raw_val);
        @(negedge clock);
        button_raw = raw_val;
        reset_n = 1'b0;
        #1;
        check_all_zero("reset_now");
        model_reset();
        repeat (2) @(posedge clock);
        #2;
        reset_n = 1'b1;
    endtask

    logic [CH-1:0] rnd_raw;
    int            rnd_len [CH];

    initial begin
        model_reset();
        repeat (3) @(posedge clock);
        #1;
        check_all_zero("por");
        #1;
        reset_n = 1'b1;

        // Press channel 0; accepted at edge M+D = 13 with a single pulse.
        for (int k = 1; k <= 16; k++) begin
            step(IDLE | 4'b0001);
            if (k == 12) check("t1_before13", button_state[0], 1'b0);
            if (k == 13) begin
                check("t1_state13", button_state, 4'b0001);
                check("t1_act13",   button_just_went_active, 4'b0001);
            end
            if (k == 14) check("t1_act_drop", button_just_went_active, 4'b0000);
        end

        // Channel 1 high for only D-1 cycles: rejected.
        for (int k = 0; k < 9; k++)  step(IDLE | 4'b0011);
        for (int k = 0; k < 15; k++) step(IDLE | 4'b0001);
        check("t2_short_rejected", button_state[1], 1'b0);

        // Channel 2 rising with a one-cycle low glitch mid-count.
        for (int k = 0; k < 5; k++) step(IDLE | 4'b0101);
        step(IDLE | 4'b0001);
        for (int k = 1; k <= 14; k++) begin
            step(IDLE | 4'b0101);
            if (k == 12) check("t2_glitch_before", button_state[2], 1'b0);
            if (k == 13) check("t2_glitch_accept", button_state[2], 1'b1);
        end

        // Active-low channel 3: raw 0 means pressed.
        for (int k = 1; k <= 14; k++) begin
            step(4'b0101);
            if (k == 12) check("t3_low_before", button_state[3], 1'b0);
            if (k == 13) check("t3_low_accept", button_state[3], 1'b1);
        end
        for (int k = 0; k < 20; k++) step(IDLE);
        check("t3_all_released", button_state, 4'b0000);

        // Simultaneous press on channels 0 and 2.
        for (int k = 1; k <= 14; k++) begin
            step(IDLE | 4'b0101);
            if (k == 13) begin
                check("t4_act_both", button_just_went_active, 4'b0101);
                check("t4_any_high", any_just_changed, 1'b1);
            end
            if (k == 14) check("t4_any_drop", any_just_changed, 1'b0);
        end

        // Reset while channel 1 is 7 counts into a press.
        for (int k = 0; k < M + 7; k++) step(IDLE | 4'b0111);
        apply_reset(IDLE | 4'b0111);
        for (int k = 1; k <= 14; k++) begin
            step(IDLE | 4'b0111);
            if (k == 12) check("t5_before13", button_state, 4'b0000);
            if (k == 13) check("t5_state13",  button_state, 4'b0111);
        end

        // Long hold for the repeat path, then release.
        for (int k = 0; k < 120; k++) step(IDLE | 4'b0111);
        for (int k = 0; k < 40; k++)  step(IDLE);

        // Randomised bouncing: mostly short bursts, occasionally long holds.
        apply_reset(IDLE);
        rnd_raw = IDLE;
        for (int c = 0; c < CH; c++) rnd_len[c] = 0;
        for (int n = 0; n < 3000; n++) begin
            for (int c = 0; c < CH; c++) begin
                if (rnd_len[c] == 0) begin
                    rnd_raw[c] = 1'($urandom_range(0, 1));
                    rnd_len[c] = ($urandom_range(0, 9) == 0) ? int'($urandom_range(60, 160))
                                                             : int'($urandom_range(1, 14));
                end
                rnd_len[c]--;
            end
            step(rnd_raw);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
